// File: rtl/adxl_resp_pkg.sv
// Shared types and constants for the ADXL-style SPI register responder.
// Holds the FSM state enum, opcodes, register addresses, ID bytes and reset values.
package adxl_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h0A;
  localparam logic [7:0] OP_READ  = 8'h0B;

  localparam logic [5:0] ADDR_DEVID_AD   = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST  = 6'h01;
  localparam logic [5:0] ADDR_PARTID     = 6'h02;
  localparam logic [5:0] ADDR_XDATA_L    = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H    = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L    = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H    = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L    = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H    = 6'h13;
  localparam logic [5:0] ADDR_FILTER_CTL = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;

  localparam logic [7:0] DEVID_AD  = 8'hAD;
  localparam logic [7:0] DEVID_MST = 8'h1D;
  localparam logic [7:0] PARTID    = 8'hF2;

  localparam logic [7:0] POWER_CTL_RST  = 8'h00;
  localparam logic [7:0] FILTER_CTL_RST = 8'h13;

  function automatic logic is_writable(input logic [5:0] addr);
    return (addr == ADDR_FILTER_CTL) || (addr == ADDR_POWER_CTL);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall detection
// in the system clock domain.
module spi_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;
  assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_resp_adxl.sv
// SPI mode-0 slave emulating a small ADXL-style register map (read 0x0B / write 0x0A).
// Define SPI_RESP_BURST_EN to auto-increment the address across data bytes.
module spi_resp_adxl
  import adxl_resp_pkg::*;
(
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs,
  output logic        miso,
  input  logic [15:0] x_val,
  input  logic [15:0] y_val,
  input  logic [15:0] z_val,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        xfer_active,
  output logic        cmd_err
);

`ifdef SPI_RESP_BURST_EN
  localparam logic BURST_EN = 1'b1;
`else
  localparam logic BURST_EN = 1'b0;
`endif

  logic       sclk_rise_s;
  logic       sclk_fall_s;
  logic       cs_rise_s;
  logic       cs_fall_s;
  logic       mosi_s;
  logic [3:0] edges_unused_s;

  spi_sync_edge u_sync_sclk (
    .clk_i  (CLK100MHZ),
    .rst_i  (rst),
    .d_i    (sclk),
    .level_o(edges_unused_s[0]),
    .rise_o (sclk_rise_s),
    .fall_o (sclk_fall_s)
  );

  spi_sync_edge u_sync_mosi (
    .clk_i  (CLK100MHZ),
    .rst_i  (rst),
    .d_i    (mosi),
    .level_o(mosi_s),
    .rise_o (edges_unused_s[1]),
    .fall_o (edges_unused_s[2])
  );

  spi_sync_edge u_sync_cs (
    .clk_i  (CLK100MHZ),
    .rst_i  (rst),
    .d_i    (cs),
    .level_o(edges_unused_s[3]),
    .rise_o (cs_rise_s),
    .fall_o (cs_fall_s)
  );

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic [7:0]  tx_q;
  logic [5:0]  addr_q;
  logic        rd_mode_q;
  logic        first_done_q;
  logic [15:0] x_snap_q;
  logic [15:0] y_snap_q;
  logic [15:0] z_snap_q;
  logic [7:0]  power_q;
  logic [7:0]  filter_q;
  logic        miso_q;
  logic        xfer_q;
  logic        cmd_err_q;

  logic [7:0]  byte_s;
  logic        byte_done_s;
  logic        service_s;
  logic [5:0]  rd_addr_s;
  logic [7:0]  rd_data_s;

  assign byte_s      = {shift_q, mosi_s};
  assign byte_done_s = sclk_rise_s && (bit_cnt_q == 3'd7);
  assign service_s   = BURST_EN || !first_done_q;

  // address being fetched: the just-received address byte, else the next burst address
  always_comb begin
    if (state_q == ST_ADDR) begin
      rd_addr_s = byte_s[5:0];
    end else begin
      rd_addr_s = addr_q + 6'd1;
    end
  end

  // register map read decode
  always_comb begin
    rd_data_s = 8'h00;
    case (rd_addr_s)
      ADDR_DEVID_AD:   rd_data_s = DEVID_AD;
      ADDR_DEVID_MST:  rd_data_s = DEVID_MST;
      ADDR_PARTID:     rd_data_s = PARTID;
      ADDR_XDATA_L:    rd_data_s = x_snap_q[7:0];
      ADDR_XDATA_H:    rd_data_s = x_snap_q[15:8];
      ADDR_YDATA_L:    rd_data_s = y_snap_q[7:0];
      ADDR_YDATA_H:    rd_data_s = y_snap_q[15:8];
      ADDR_ZDATA_L:    rd_data_s = z_snap_q[7:0];
      ADDR_ZDATA_H:    rd_data_s = z_snap_q[15:8];
      ADDR_FILTER_CTL: rd_data_s = filter_q;
      ADDR_POWER_CTL:  rd_data_s = power_q;
      default:         rd_data_s = 8'h00;
    endcase
  end

  // transaction FSM with registered outputs
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      tx_q         <= 8'h00;
      addr_q       <= 6'd0;
      rd_mode_q    <= 1'b0;
      first_done_q <= 1'b0;
      x_snap_q     <= 16'h0000;
      y_snap_q     <= 16'h0000;
      z_snap_q     <= 16'h0000;
      power_q      <= POWER_CTL_RST;
      filter_q     <= FILTER_CTL_RST;
      miso_q       <= 1'b0;
      xfer_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      if (cs_rise_s) begin
        // deselect aborts whatever is in flight; an unfinished byte is simply dropped
        state_q <= ST_IDLE;
        xfer_q  <= 1'b0;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall_s) begin
              state_q      <= ST_CMD;
              xfer_q       <= 1'b1;
              miso_q       <= 1'b0;
              bit_cnt_q    <= 3'd0;
              first_done_q <= 1'b0;
              x_snap_q     <= x_val;
              y_snap_q     <= y_val;
              z_snap_q     <= z_val;
            end
          end
          ST_CMD: begin
            if (sclk_rise_s) begin
              shift_q   <= byte_s[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (byte_done_s) begin
                if (byte_s == OP_READ) begin
                  rd_mode_q <= 1'b1;
                  state_q   <= ST_ADDR;
                end else if (byte_s == OP_WRITE) begin
                  rd_mode_q <= 1'b0;
                  state_q   <= ST_ADDR;
                end else begin
                  cmd_err_q <= 1'b1;
                  state_q   <= ST_ERR;
                end
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise_s) begin
              shift_q   <= byte_s[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (byte_done_s) begin
                addr_q  <= byte_s[5:0];
                tx_q    <= rd_data_s;
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise_s) begin
              shift_q   <= byte_s[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (byte_done_s) begin
                if (!rd_mode_q && service_s && is_writable(addr_q)) begin
                  if (addr_q == ADDR_POWER_CTL) begin
                    power_q <= byte_s;
                  end else begin
                    filter_q <= byte_s;
                  end
                end
                first_done_q <= 1'b1;
                // without burst only the first data byte is live; later ones read zero
                if (BURST_EN) begin
                  addr_q <= addr_q + 6'd1;
                  tx_q   <= rd_data_s;
                end else begin
                  tx_q   <= 8'h00;
                end
              end
            end else if (sclk_fall_s && rd_mode_q) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end
          ST_ERR: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            xfer_q  <= 1'b0;
            miso_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign miso        = miso_q;
  assign power_ctl   = power_q;
  assign filter_ctl  = filter_q;
  assign xfer_active = xfer_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_resp_adxl.sv
// Self-checking bench for spi_resp_adxl: directed table, corner sequences and
// randomized transactions scored against a register-map model.
module tb_spi_resp_adxl;

`ifdef SPI_RESP_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        mosi;
  logic        cs;
  logic        miso;
  logic [15:0] x_val;
  logic [15:0] y_val;
  logic [15:0] z_val;
  logic [7:0]  power_ctl;
  logic [7:0]  filter_ctl;
  logic        xfer_active;
  logic        cmd_err;

  spi_resp_adxl dut (
    .CLK100MHZ  (clk),
    .rst        (rst),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs         (cs),
    .miso       (miso),
    .x_val      (x_val),
    .y_val      (y_val),
    .z_val      (z_val),
    .power_ctl  (power_ctl),
    .filter_ctl (filter_ctl),
    .xfer_active(xfer_active),
    .cmd_err    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_pulses = 0;

  always @(negedge clk) begin
    if (cmd_err === 1'b1) err_pulses <= err_pulses + 1;
  end

  logic [7:0]  tx_buf [0:5];
  logic [7:0]  rx_buf [0:5];
  logic        mid_en;
  logic [15:0] mid_x, mid_y, mid_z;
  logic [7:0]  pwr_pre_cs, flt_pre_cs;
  logic [7:0]  m_pwr, m_flt;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int half, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (half) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int nb, input int half);
    logic [7:0] rxb;
    cs = 1'b0;
    repeat (half) @(negedge clk);
    chk("xfer_active_on", 0, {31'd0, xfer_active}, 32'd1);
    for (int b = 0; b < nb; b++) begin
      spi_byte(tx_buf[b], half, rxb);
      rx_buf[b] = rxb;
      if (b == 1 && mid_en) begin
        x_val = mid_x;
        y_val = mid_y;
        z_val = mid_z;
      end
    end
    repeat (half) @(negedge clk);
    pwr_pre_cs = power_ctl;
    flt_pre_cs = filter_ctl;
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [7:0] m_map(input logic [5:0] a, input logic [15:0] sx, input logic [15:0] sy,
                                       input logic [15:0] sz);
    case (a)
      6'h00:   return 8'hAD;
      6'h01:   return 8'h1D;
      6'h02:   return 8'hF2;
      6'h0E:   return sx[7:0];
      6'h0F:   return sx[15:8];
      6'h10:   return sy[7:0];
      6'h11:   return sy[15:8];
      6'h12:   return sz[7:0];
      6'h13:   return sz[15:8];
      6'h2C:   return m_flt;
      6'h2D:   return m_pwr;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    logic [7:0] op;
    logic [7:0] addr;
    int         n;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] epwr;
    logic [7:0] eflt;
    int         eerr;
  } vec_t;

  localparam logic [7:0] PWR8 = BURST ? 8'h05 : 8'h02;
  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  logic [7:0] pool [12];
  logic [7:0] rxb;
  logic [7:0] op, abyte;
  logic [5:0] a6, a;
  logic [15:0] sx, sy, sz;
  logic [7:0] exp_rd [0:2];
  int hp, nd, e0, cyc;

  initial begin
    tbl[0]  = '{8'h0B, 8'h00, 1, 8'h00, 8'h00, 8'hAD, 8'h00, 8'h00, 8'h13, 0};
    tbl[1]  = '{8'h0B, 8'h01, 1, 8'h00, 8'h00, 8'h1D, 8'h00, 8'h00, 8'h13, 0};
    tbl[2]  = '{8'h0B, 8'h02, 1, 8'h00, 8'h00, 8'hF2, 8'h00, 8'h00, 8'h13, 0};
    tbl[3]  = '{8'h0A, 8'h2D, 1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02, 8'h13, 0};
    tbl[4]  = '{8'h0B, 8'h2D, 1, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h13, 0};
    tbl[5]  = '{8'h0B, 8'h0E, 2, 8'h00, 8'h00, 8'h23, BURST ? 8'h01 : 8'h00, 8'h02, 8'h13, 0};
    tbl[6]  = '{8'h0B, 8'h13, 1, 8'h00, 8'h00, 8'h89, 8'h00, 8'h02, 8'h13, 0};
    tbl[7]  = '{8'h0B, 8'h10, 1, 8'h00, 8'h00, 8'h67, 8'h00, 8'h02, 8'h13, 0};
    tbl[8]  = '{8'h0A, 8'h2C, 2, 8'h1A, 8'h05, 8'h00, 8'h00, PWR8, 8'h1A, 0};
    tbl[9]  = '{8'h0B, 8'h2C, 2, 8'h00, 8'h00, 8'h1A, BURST ? PWR8 : 8'h00, PWR8, 8'h1A, 0};
    tbl[10] = '{8'h0B, 8'h3F, 2, 8'h00, 8'h00, 8'h00, BURST ? 8'hAD : 8'h00, PWR8, 8'h1A, 0};
    tbl[11] = '{8'h0A, 8'h00, 1, 8'h55, 8'h00, 8'h00, 8'h00, PWR8, 8'h1A, 0};
    tbl[12] = '{8'h0B, 8'h00, 1, 8'h00, 8'h00, 8'hAD, 8'h00, PWR8, 8'h1A, 0};
    tbl[13] = '{8'h55, 8'h2D, 1, 8'h77, 8'h00, 8'h00, 8'h00, PWR8, 8'h1A, 1};
    tbl[14] = '{8'h0B, 8'h0F, 1, 8'h00, 8'h00, 8'h01, 8'h00, PWR8, 8'h1A, 0};
    tbl[15] = '{8'h0B, 8'hED, 1, 8'h00, 8'h00, PWR8, 8'h00, PWR8, 8'h1A, 0};
    pool = '{8'h00, 8'h01, 8'h02, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h2C, 8'h2D, 8'h3F};

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; mid_en = 1'b0;
    mid_x = 16'h0; mid_y = 16'h0; mid_z = 16'h0;
    x_val = 16'h0123; y_val = 16'h4567; z_val = 16'h89AB;
    repeat (3) @(negedge clk);
    chk("rst_miso", 0, {31'd0, miso}, 32'd0);
    chk("rst_xfer_active", 0, {31'd0, xfer_active}, 32'd0);
    chk("rst_cmd_err", 0, {31'd0, cmd_err}, 32'd0);
    chk("rst_power_ctl", 0, {24'd0, power_ctl}, 32'h00);
    chk("rst_filter_ctl", 0, {24'd0, filter_ctl}, 32'h13);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // directed table at 1 MHz sclk
    for (int v = 0; v < NVEC; v++) begin
      tx_buf[0] = tbl[v].op; tx_buf[1] = tbl[v].addr;
      tx_buf[2] = tbl[v].wd0; tx_buf[3] = tbl[v].wd1;
      e0 = err_pulses;
      spi_xfer(tbl[v].n + 2, 50);
      chk("tbl_cmd_miso", v, {24'd0, rx_buf[0]}, 32'd0);
      chk("tbl_addr_miso", v, {24'd0, rx_buf[1]}, 32'd0);
      chk("tbl_data0", v, {24'd0, rx_buf[2]}, {24'd0, tbl[v].e0});
      if (tbl[v].n > 1) chk("tbl_data1", v, {24'd0, rx_buf[3]}, {24'd0, tbl[v].e1});
      chk("tbl_pwr_pre_cs", v, {24'd0, pwr_pre_cs}, {24'd0, tbl[v].epwr});
      chk("tbl_power_ctl", v, {24'd0, power_ctl}, {24'd0, tbl[v].epwr});
      chk("tbl_filter_ctl", v, {24'd0, filter_ctl}, {24'd0, tbl[v].eflt});
      chk("tbl_cmd_err_cnt", v, err_pulses - e0, tbl[v].eerr);
      chk("tbl_xfer_idle", v, {31'd0, xfer_active}, 32'd0);
    end

    // sensor change mid-burst must not disturb the snapshot
    x_val = 16'h0123;
    mid_en = 1'b1; mid_x = 16'h0FFF; mid_y = y_val; mid_z = z_val;
    tx_buf[0] = 8'h0B; tx_buf[1] = 8'h0E; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    spi_xfer(4, 50);
    mid_en = 1'b0;
    chk("snap_lo", 0, {24'd0, rx_buf[2]}, 32'h23);
    chk("snap_hi", 0, {24'd0, rx_buf[3]}, BURST ? 32'h01 : 32'h00);

    // cs raised after four bits of a write data byte
    cs = 1'b0;
    repeat (50) @(negedge clk);
    spi_byte(8'h0A, 50, rxb);
    spi_byte(8'h2C, 50, rxb);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      repeat (50) @(negedge clk);
      sclk = 1'b1;
      repeat (50) @(negedge clk);
      sclk = 1'b0;
    end
    cs = 1'b1;
    cyc = 0;
    while (xfer_active === 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_latency_le4", cyc, {31'd0, (cyc <= 4)}, 32'd1);
    repeat (10) @(negedge clk);
    chk("abort_filter_ctl", 0, {24'd0, filter_ctl}, {24'd0, tbl[8].wd0});

    // reset in the middle of a write: bus ignored until a fresh cs fall
    cs = 1'b0;
    repeat (10) @(negedge clk);
    spi_byte(8'h0A, 10, rxb);
    spi_byte(8'h2D, 10, rxb);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_xfer", 0, {31'd0, xfer_active}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h07, 10, rxb);
    repeat (10) @(negedge clk);
    chk("midrst_power_ctl", 0, {24'd0, power_ctl}, 32'h00);
    chk("midrst_filter_ctl", 0, {24'd0, filter_ctl}, 32'h13);
    chk("midrst_xfer_after", 0, {31'd0, xfer_active}, 32'd0);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    m_pwr = 8'h00; m_flt = 8'h13;
    tx_buf[0] = 8'h0B; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    spi_xfer(3, 10);
    chk("midrst_readback", 0, {24'd0, rx_buf[2]}, 32'hAD);

    // randomized transactions against the register-map model
    for (int t = 0; t < 30; t++) begin
      hp = $urandom_range(4, 10);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: op = 8'h0B;
        5, 6, 7, 8:    op = 8'h0A;
        default: begin
          op = 8'($urandom);
          if (op == 8'h0A || op == 8'h0B) op = 8'h55;
        end
      endcase
      if ($urandom_range(0, 3) == 0) a6 = 6'($urandom);
      else a6 = pool[$urandom_range(0, 11)][5:0];
      abyte = {2'($urandom), a6};
      nd = $urandom_range(1, 3);
      sx = 16'($urandom); sy = 16'($urandom); sz = 16'($urandom);
      x_val = sx; y_val = sy; z_val = sz;
      mid_en = 1'($urandom);
      mid_x = 16'($urandom); mid_y = 16'($urandom); mid_z = 16'($urandom);
      tx_buf[0] = op; tx_buf[1] = abyte;
      for (int i = 0; i < 3; i++) tx_buf[2 + i] = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
        a = 6'((32'(a6) + i) % 64);
        exp_rd[i] = (op == 8'h0B && (BURST || i == 0)) ? m_map(a, sx, sy, sz) : 8'h00;
      end
      e0 = err_pulses;
      spi_xfer(nd + 2, hp);
      if (op == 8'h0A) begin
        for (int i = 0; i < nd; i++) begin
          a = 6'((32'(a6) + i) % 64);
          if (BURST || i == 0) begin
            if (a == 6'h2C) m_flt = tx_buf[2 + i];
            else if (a == 6'h2D) m_pwr = tx_buf[2 + i];
          end
        end
      end
      chk("rnd_cmd_miso", t, {24'd0, rx_buf[0]}, 32'd0);
      chk("rnd_addr_miso", t, {24'd0, rx_buf[1]}, 32'd0);
      for (int i = 0; i < nd; i++) chk("rnd_data", t * 4 + i, {24'd0, rx_buf[2 + i]}, {24'd0, exp_rd[i]});
      chk("rnd_power_ctl", t, {24'd0, power_ctl}, {24'd0, m_pwr});
      chk("rnd_filter_ctl", t, {24'd0, filter_ctl}, {24'd0, m_flt});
      chk("rnd_cmd_err_cnt", t, err_pulses - e0, (op != 8'h0A && op != 8'h0B) ? 32'd1 : 32'd0);
    end
    mid_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_resp_adxl.md
SPI_RESP_ADXL -- requirements
Module: spi_resp_adxl

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset; all other ports are listed below.
- CLK100MHZ  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  synchronous active-high reset.
REQ-002 SHALL expose these SPI ports, all asynchronous to CLK100MHZ:
- sclk  in  1  SPI mode 0 serial clock.
- mosi  in  1  serial data in.
- cs  in  1  chip select, active low.
- miso  out  1  serial data out.
REQ-003 SHALL expose these sensor-value inputs:
- x_val  in  16  X sample.
- y_val  in  16  Y sample.
- z_val  in  16  Z sample.
REQ-004 SHALL expose these status/control outputs:
- power_ctl  out  8  POWER_CTL register contents.
- filter_ctl  out  8  FILTER_CTL register contents.
- xfer_active  out  1  high while a transaction is in progress.
- cmd_err  out  1  one-cycle pulse on an unknown command.

Function
REQ-005 SHALL pass sclk, mosi and cs through 2-FF synchronizers, then edge-detect sclk and cs in the CLK100MHZ domain.
REQ-006 SHALL operate correctly for any sclk high time and low time of at least 4 CLK100MHZ cycles each.
REQ-007 SHALL sample mosi, MSB first, on each detected sclk rise.
REQ-008 SHALL update miso within 3 CLK100MHZ cycles of each detected sclk fall.
REQ-009 SHALL implement the state machine IDLE -> CMD -> ADDR -> DATA, plus a state ERR.
- IDLE: left on detected cs fall.
- Any state: returns to IDLE on detected cs rise.
REQ-010 CMD SHALL accept 0x0B (read) and 0x0A (write).
- Any other byte: pulse cmd_err for one cycle and enter ERR.
- ERR: miso=0; all input ignored until cs rises.
REQ-011 ADDR SHALL latch a 6-bit address taken from bits [5:0] of the second byte.
REQ-012 Read: the data MSB SHALL be driven on the sclk fall following the 16th sclk rise.
- The byte is fetched from the register map at the current address.
REQ-013 Write: on the 8th sclk rise of each data byte, the byte SHALL be committed if the address is writable.
- A write to any other address is ignored.
REQ-014 Register map:
- 0x00 = 0xAD
- 0x01 = 0x1D
- 0x02 = 0xF2
- 0x0E/0x0F = X low/high
- 0x10/0x11 = Y low/high
- 0x12/0x13 = Z low/high
- 0x2C = filter_ctl (R/W)
- 0x2D = power_ctl (R/W)
- All other addresses read 0x00.
REQ-015 On the detected cs fall, x_val, y_val and z_val SHALL be snapshotted, giving coherent data for the whole transaction.
REQ-016 If cs rises mid-byte, the transaction SHALL abort and any partial write byte is discarded.
REQ-017 miso SHALL be 0 whenever the state is not DATA-read.
REQ-018 xfer_active SHALL be high in CMD, ADDR, DATA and ERR.

Reset
REQ-019 With rst high, on the next clock edge:
- state=IDLE
- miso=0
- xfer_active=0
- cmd_err=0
- power_ctl=0x00
- filter_ctl=0x13
- snapshots=0
- synchronizers cleared
REQ-020 rst asserted mid-transaction SHALL abort it.
- The block then ignores the bus until the next cs fall seen after rst is released.

Configuration
REQ-021 With SPI_RESP_BURST_EN defined: after each data byte, the address SHALL auto-increment, wrapping 0x3F->0x00, and reads/writes continue until cs rises.
REQ-022 With SPI_RESP_BURST_EN undefined: only the first data byte is serviced; later bytes read 0x00 and writes are ignored.

Structure
REQ-023 A shared package adxl_resp_pkg SHALL hold:
- the state enum
- the opcodes 0x0A/0x0B
- the register addresses
- the ID constants
- the reset values
REQ-024 The synchronizer and edge detect SHALL be a sub-module named spi_sync_edge, instantiated three times.

Verification
REQ-025 Directed scenarios, sclk=1 MHz:
- rst, then read 0x00 -> miso returns 0xAD; power_ctl=0x00; filter_ctl=0x13.
- Write 0x0A,0x2D,0x02 -> power_ctl=0x02 after the 8th data-bit rise; a read-back returns 0x02.
- x_val=0x0123, read burst 0x0B,0x0E,2 bytes -> 0x23,0x01 (BURST_EN); without BURST_EN the second byte is 0x00.
- x_val changed from 0x0123 to 0x0FFF mid-transaction -> the burst still returns 0x23,0x01.
- Command 0x55 -> cmd_err pulses once, miso stays 0, and the next transaction works normally.
- cs raised after 4 bits of a write data byte -> the register is unchanged and xfer_active falls within 4 cycles.
